mul_accumulator: RTL and testbench



---
 rtl/mul_accumulator.sv | 139 +++++++++++++
 tb/tb_mul_accumulator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_accumulator.sv
// Multiply-accumulate consumer: sums blocks of (len+1) 8-bit products and returns sum, sticky overflow and beat count.
// Optional build macro MUL_ACC_SATURATE_EN clamps the accumulator on carry-out instead of wrapping.
module mul_accumulator #(
  parameter int ACC_WIDTH   = 16,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_prod,
  input  logic                   in_ovf,
  input  logic [COUNT_WIDTH-1:0] len,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_sum,
  output logic                   out_ovf,
  output logic [COUNT_WIDTH:0]   out_count
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [COUNT_WIDTH:0]   CNT_ONE = 1;
  localparam logic [COUNT_WIDTH-1:0] REM_ONE = 1;

  function automatic logic [ACC_WIDTH-1:0] zext_prod(input logic [7:0] p);
    return {{(ACC_WIDTH-8){1'b0}}, p};
  endfunction

  // Returns {carry, next_acc}; in the saturating build a carry pins the sum at all ones.
  function automatic logic [ACC_WIDTH:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [7:0]           p);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, zext_prod(p)};
`ifdef MUL_ACC_SATURATE_EN
    if (s[ACC_WIDTH]) s[ACC_WIDTH-1:0] = '1;
`endif
    return s;
  endfunction

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic [COUNT_WIDTH:0]   count_q, count_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]   out_sum_q, out_sum_d;
  logic                   out_ovf_q, out_ovf_d;
  logic [COUNT_WIDTH:0]   out_count_q, out_count_d;
  logic [ACC_WIDTH:0]     sum_w;
  logic                   load_first;

  // A finished block only frees the input side when the result is being taken.
  assign in_ready = (state_q != DONE) || out_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    load_first  = 1'b0;
    sum_w       = acc_add(acc_q, in_prod);

    unique case (state_q)
      IDLE: begin
        load_first = in_valid;
      end
      ACC: begin
        if (in_valid) begin
          acc_d       = sum_w[ACC_WIDTH-1:0];
          ovf_d       = ovf_q | in_ovf | sum_w[ACC_WIDTH];
          count_d     = count_q + CNT_ONE;
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            load_first = 1'b1;
          end else begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // First beat of a block; also used for the same-cycle handoff out of DONE.
    if (load_first) begin
      acc_d       = zext_prod(in_prod);
      ovf_d       = in_ovf;
      count_d     = CNT_ONE;
      remaining_d = len;
      state_d     = (len == '0) ? DONE : ACC;
    end

    out_valid_d = (state_d == DONE);
    out_sum_d   = out_valid_d ? acc_d   : '0;
    out_ovf_d   = out_valid_d ? ovf_d   : 1'b0;
    out_count_d = out_valid_d ? count_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed bench for mul_accumulator: a 16-bit accumulator instance plus an 8-bit one for wrap/saturate.
module tb_mul_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ovf = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_prod = 8'h00;
  logic [3:0]  len = 4'h0;
  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_sum;
  logic [4:0]  out_count;

  logic        in_valid8 = 1'b0, in_ovf8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0]  in_prod8 = 8'h00;
  logic [3:0]  len8 = 4'h0;
  logic        in_ready8, out_valid8, out_ovf8;
  logic [7:0]  out_sum8;
  logic [4:0]  out_count8;

  int n_tests = 0;
  int n_fail  = 0;

  mul_accumulator #(.ACC_WIDTH(16), .COUNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_ovf(in_ovf), .len(len), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf), .out_count(out_count)
  );

  mul_accumulator #(.ACC_WIDTH(8), .COUNT_WIDTH(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_prod(in_prod8), .in_ovf(in_ovf8), .len(len8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_sum(out_sum8), .out_ovf(out_ovf8), .out_count(out_count8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] p, input logic o, input logic [3:0] l);
    in_valid = 1'b1; in_prod = p; in_ovf = o; len = l;
    tick();
    in_valid = 1'b0; in_ovf = 1'b0; in_prod = 8'h00;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_count !== 5'd0) begin
      n_fail++;
      $display("FAIL %s_drain: valid=%b sum=%h count=%0d, want 0/0000/0", name, out_valid, out_sum, out_count);
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_ovf !== 1'b0 || out_count !== 5'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: valid=%b sum=%h ovf=%b count=%0d rdy=%b, want 0/0000/0/0/1",
               out_valid, out_sum, out_ovf, out_count, in_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    beat(8'h2A, 1'b0, 4'd0);
    n_tests++;
    if (out_valid !== 1'b1 || out_sum !== 16'h002A || out_ovf !== 1'b0 || out_count !== 5'd1) begin
      n_fail++;
      $display("FAIL single: valid=%b sum=%h ovf=%b count=%0d, want 1/002a/0/1", out_valid, out_sum, out_ovf, out_count);
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_in_ready: got %b want 0", in_ready);
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_in_ready_follow: got %b want 1", in_ready);
    end
    out_ready = 1'b0;
    drain("single");
  endtask

  task automatic test_block4();
    logic [7:0] prods [4];
    prods = '{8'd10, 8'd20, 8'd30, 8'd40};
    for (int i = 0; i < 4; i++) begin
      // len on later beats is garbage on purpose; only the first beat's len counts
      beat(prods[i], 1'b0, (i == 0) ? 4'd3 : 4'd0);
      if (i < 3) begin
        for (int b = 0; b < 2; b++) begin
          n_tests++;
          if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL block4_early beat %0d: valid=%b rdy=%b, want 0/1", i, out_valid, in_ready);
          end
          tick();
        end
      end
    end
    n_tests++;
    if (out_valid !== 1'b1 || out_sum !== 16'd100 || out_ovf !== 1'b0 || out_count !== 5'd4) begin
      n_fail++;
      $display("FAIL block4: valid=%b sum=%0d ovf=%b count=%0d, want 1/100/0/4", out_valid, out_sum, out_ovf, out_count);
    end
    drain("block4");
  endtask

  task automatic test_sticky();
    beat(8'd5, 1'b0, 4'd2);
    beat(8'd6, 1'b1, 4'd0);
    beat(8'd7, 1'b0, 4'd0);
    n_tests++;
    if (out_valid !== 1'b1 || out_sum !== 16'd18 || out_ovf !== 1'b1 || out_count !== 5'd3) begin
      n_fail++;
      $display("FAIL sticky: valid=%b sum=%0d ovf=%b count=%0d, want 1/18/1/3", out_valid, out_sum, out_ovf, out_count);
    end
    drain("sticky");
  endtask

  task automatic test_wrap();
    logic [7:0] exp_sum;
`ifdef MUL_ACC_SATURATE_EN
    exp_sum = 8'hFF;
`else
    exp_sum = 8'h10;
`endif
    in_valid8 = 1'b1; in_prod8 = 8'hF0; len8 = 4'd1;
    tick();
    in_prod8 = 8'h20; len8 = 4'd0;
    tick();
    in_valid8 = 1'b0;
    n_tests++;
    if (out_valid8 !== 1'b1 || out_sum8 !== exp_sum || out_ovf8 !== 1'b1 || out_count8 !== 5'd2) begin
      n_fail++;
      $display("FAIL wrap: valid=%b sum=%h ovf=%b count=%0d, want 1/%h/1/2", out_valid8, out_sum8, out_ovf8, out_count8, exp_sum);
    end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    n_tests++;
    if (out_valid8 !== 1'b0 || out_sum8 !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_drain: valid=%b sum=%h, want 0/00", out_valid8, out_sum8);
    end
  endtask

  task automatic test_back_to_back();
    beat(8'h11, 1'b0, 4'd0);
    in_valid = 1'b1; in_prod = 8'd9; in_ovf = 1'b0; len = 4'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_sum !== 16'h0011 || out_count !== 5'd1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold cycle %0d: valid=%b sum=%h count=%0d rdy=%b, want 1/0011/1/0",
                 c, out_valid, out_sum, out_count, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL handoff_in_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_sum !== 16'd9 || out_count !== 5'd1 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL handoff: valid=%b sum=%0d count=%0d ovf=%b, want 1/9/1/0", out_valid, out_sum, out_count, out_ovf);
    end
    out_ready = 1'b0;
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    beat(8'd1, 1'b0, 4'd3);
    beat(8'd2, 1'b0, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_ovf !== 1'b0 || out_count !== 5'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b sum=%h ovf=%b count=%0d rdy=%b, want 0/0000/0/0/1",
               out_valid, out_sum, out_ovf, out_count, in_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    beat(8'd3, 1'b0, 4'd0);
    n_tests++;
    if (out_valid !== 1'b1 || out_sum !== 16'd3 || out_count !== 5'd1 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: valid=%b sum=%0d count=%0d ovf=%b, want 1/3/1/0", out_valid, out_sum, out_count, out_ovf);
    end
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_block4();
    test_sticky();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
